// File: rtl/data_mem_lsu_if.sv
// Byte-wide handshaked memory bus between the load/store unit (master) and memory (slave).
// A byte moves in any cycle where bus_req and bus_ack are both high.
interface data_mem_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Load/store unit: splits b/h/w accesses into little-endian byte transfers on the byte bus,
// stalls the datapath meanwhile and returns sign/zero-extended load data.
module data_mem_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [2:0]            RW_type_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  stall_o,
  output logic                  err_o,
  data_mem_lsu_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  type_q, type_d;
  logic        dir_q, dir_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req;
  logic        legal;
  logic        lastByte;
  logic [1:0]  lastCnt;
  logic [31:0] asmNext;
  logic        stallComb;

  function automatic logic loadTypeOk(input logic [2:0] t);
    case (t)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: loadTypeOk = 1'b1;
      default:                                loadTypeOk = 1'b0;
    endcase
  endfunction

  function automatic logic storeTypeOk(input logic [2:0] t);
    case (t)
      3'b000, 3'b001, 3'b010: storeTypeOk = 1'b1;
      default:                storeTypeOk = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extendLoad(input logic [31:0] a, input logic [2:0] t);
    case (t)
      3'b000:  extendLoad = {{24{a[7]}}, a[7:0]};
      3'b001:  extendLoad = {{16{a[15]}}, a[15:0]};
      3'b100:  extendLoad = {24'h000000, a[7:0]};
      3'b101:  extendLoad = {16'h0000, a[15:0]};
      default: extendLoad = a;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      type_q  <= type_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req   = MemRead_i | MemWrite_i;
    legal = req && !(MemRead_i && MemWrite_i) &&
            (MemRead_i ? loadTypeOk(RW_type_i) : storeTypeOk(RW_type_i));

    case (type_q[1:0])
      2'b00:   lastCnt = 2'd0;
      2'b01:   lastCnt = 2'd1;
      default: lastCnt = 2'd3;
    endcase
    lastByte = (cnt_q == lastCnt);

    // Assembly register as it will look once the byte on the bus is captured.
    asmNext = asm_q;
    asmNext[{cnt_q, 3'b000} +: 8] = bus.bus_rdata;

    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    type_d    = type_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    asm_d     = asm_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    stallComb = 1'b0;

    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;

    case (state_q)
      IDLE: begin
        stallComb = legal;
        if (legal) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          type_d  = RW_type_i;
          dir_d   = MemWrite_i;
          cnt_d   = 2'd0;
          tmo_d   = 8'd0;
          state_d = XFER;
        end else if (req) begin
          err_d = 1'b1;
        end
      end

      XFER: begin
        stallComb     = 1'b1;
        bus.bus_req   = 1'b1;
        bus.bus_we    = dir_q;
        bus.bus_addr  = addr_q + {30'd0, cnt_q};
        bus.bus_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
        if (bus.bus_ack) begin
          tmo_d = 8'd0;
          if (!dir_q) begin
            asm_d = asmNext;
          end
          if (lastByte) begin
            state_d = DONE;
            if (!dir_q) begin
              rdata_d = extendLoad(asmNext, type_q);
            end
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Abandoned access: rdata keeps its previous value.
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall is combinational in IDLE, so it is gated to stay low while reset is held.
  assign stall_o = stallComb & rst_n;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: stimulus pushes expected bus bytes, load results and
// error pulses; a monitor pops and compares them as the DUT presents them.
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  rwType;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  data_mem_lsu_if busIf();

  data_mem_lsu #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemRead_i  (memRead),
    .MemWrite_i (memWrite),
    .RW_type_i  (rwType),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rdata_o    (rdata),
    .stall_o    (stall),
    .err_o      (err),
    .bus        (busIf.master)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_BUS = 0, EV_DONE = 1, EV_ERR = 2} evKind_e;

  typedef struct {
    evKind_e     kind;
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [31:0] rdata;
    logic        err;
  } expItem_t;

  expItem_t   expQ[$];
  logic [7:0] slvQ[$];
  int         slvWait = 0;
  bit         slvMute = 1'b0;
  int         slvWaitCnt = 0;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state
  logic        prevStall;
  logic        prevWait;
  logic [31:0] heldAddr;
  logic        heldWe;
  logic [7:0]  heldWdata;
  expItem_t    popped;
  bit          popOk;

  function automatic expItem_t mkItem(input evKind_e k, input logic [31:0] a, input logic we,
                                      input logic [7:0] wd, input logic [31:0] rd, input logic e);
    expItem_t it;
    it.kind  = k;
    it.addr  = a;
    it.we    = we;
    it.wdata = wd;
    it.rdata = rd;
    it.err   = e;
    return it;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic popExpect(input evKind_e k, output expItem_t it, output bit ok);
    ok = 1'b0;
    it = mkItem(EV_BUS, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0);
    if (expQ.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL unexpected event kind %0d at %0t (scoreboard empty)", int'(k), $time);
    end else begin
      it = expQ.pop_front();
      checkOutput("event kind", 32'(int'(it.kind)), 32'(int'(k)));
      ok = (it.kind == k);
    end
  endtask

  // Memory slave: acks each requested byte after slvWait idle cycles, returning bytes from slvQ.
  initial begin
    busIf.bus_ack   = 1'b0;
    busIf.bus_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !busIf.bus_req) begin
        busIf.bus_ack = 1'b0;
        slvWaitCnt    = 0;
      end else if (!slvMute && slvWaitCnt >= slvWait) begin
        busIf.bus_ack   = 1'b1;
        busIf.bus_rdata = (slvQ.size() > 0) ? slvQ.pop_front() : 8'h00;
        slvWaitCnt      = 0;
      end else begin
        busIf.bus_ack = 1'b0;
        slvWaitCnt++;
      end
    end
  end

  // Monitor: compares every presented bus byte, completed access and error pulse.
  initial begin
    prevStall = 1'b0;
    prevWait  = 1'b0;
    heldAddr  = '0;
    heldWe    = 1'b0;
    heldWdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevStall = 1'b0;
        prevWait  = 1'b0;
        continue;
      end
      if (prevStall && !stall) begin
        popExpect(EV_DONE, popped, popOk);
        if (popOk) begin
          checkOutput("done rdata", rdata, popped.rdata);
          checkOutput("done err", 32'(err), 32'(popped.err));
        end
      end else if (err) begin
        popExpect(EV_ERR, popped, popOk);
      end
      if (busIf.bus_req && busIf.bus_ack) begin
        popExpect(EV_BUS, popped, popOk);
        if (popOk) begin
          checkOutput("bus addr", busIf.bus_addr, popped.addr);
          checkOutput("bus we", 32'(busIf.bus_we), 32'(popped.we));
          if (popped.we) checkOutput("bus wdata", 32'(busIf.bus_wdata), 32'(popped.wdata));
        end
      end
      if (busIf.bus_req && prevWait) begin
        checkOutput("held addr", busIf.bus_addr, heldAddr);
        checkOutput("held we", 32'(busIf.bus_we), 32'(heldWe));
        checkOutput("held wdata", 32'(busIf.bus_wdata), 32'(heldWdata));
      end
      prevWait  = busIf.bus_req && !busIf.bus_ack;
      heldAddr  = busIf.bus_addr;
      heldWe    = busIf.bus_we;
      heldWdata = busIf.bus_wdata;
      prevStall = stall;
    end
  end

  // Holds a request until the DONE cycle, counting stall and bus_req cycles.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] t,
                               input logic [31:0] a, input logic [31:0] wd,
                               output int stallCycles, output int reqCycles);
    bit done;
    @(posedge clk);
    #1;
    memRead  = rd;
    memWrite = wr;
    rwType   = t;
    addr     = a;
    wdata    = wd;
    stallCycles = 0;
    reqCycles   = 0;
    done        = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (busIf.bus_req) reqCycles++;
      if (stall) stallCycles++;
      else if (stallCycles > 0) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL access completion: no DONE within 60 cycles, required one");
    end
    @(posedge clk);
    #1;
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic applyIllegal(input logic rd, input logic wr, input logic [2:0] t);
    expQ.push_back(mkItem(EV_ERR, 32'h0, 1'b0, 8'h00, 32'h0, 1'b1));
    @(posedge clk);
    #1;
    memRead  = rd;
    memWrite = wr;
    rwType   = t;
    @(negedge clk);
    checkOutput("illegal stall", 32'(stall), 32'h0);
    checkOutput("illegal bus_req", 32'(busIf.bus_req), 32'h0);
    @(posedge clk);
    #1;
    memRead  = 1'b0;
    memWrite = 1'b0;
    @(negedge clk);
    checkOutput("illegal bus_req after", 32'(busIf.bus_req), 32'h0);
    checkOutput("illegal stall after", 32'(stall), 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sc;
    int rc;
    rst_n    = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    rwType   = 3'b000;
    addr     = '0;
    wdata    = '0;
    #1;
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset stall", 32'(stall), 32'h0);
    checkOutput("reset err", 32'(err), 32'h0);
    checkOutput("reset bus_req", 32'(busIf.bus_req), 32'h0);
    checkOutput("reset bus_we", 32'(busIf.bus_we), 32'h0);
    checkOutput("reset bus_addr", busIf.bus_addr, 32'h0);
    checkOutput("reset bus_wdata", 32'(busIf.bus_wdata), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] lw 0x100");
    slvWait = 0;
    slvQ = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 4; i++)
      expQ.push_back(mkItem(EV_BUS, 32'h100 + 32'(i), 1'b0, 8'h00, 32'h0, 1'b0));
    expQ.push_back(mkItem(EV_DONE, 32'h0, 1'b0, 8'h00, 32'h12345678, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, sc, rc);
    checkOutput("lw stall cycles", 32'(sc), 32'd5);
    checkOutput("lw req cycles", 32'(rc), 32'd4);
    checkOutput("lw rdata held", rdata, 32'h12345678);

    $display("[TB] lb / lbu / lh");
    slvQ = '{8'h80};
    expQ.push_back(mkItem(EV_BUS, 32'h3, 1'b0, 8'h00, 32'h0, 1'b0));
    expQ.push_back(mkItem(EV_DONE, 32'h0, 1'b0, 8'h00, 32'hFFFFFF80, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h3, 32'h0, sc, rc);
    checkOutput("lb stall cycles", 32'(sc), 32'd2);
    slvQ = '{8'h80};
    expQ.push_back(mkItem(EV_BUS, 32'h3, 1'b0, 8'h00, 32'h0, 1'b0));
    expQ.push_back(mkItem(EV_DONE, 32'h0, 1'b0, 8'h00, 32'h00000080, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h3, 32'h0, sc, rc);
    slvQ = '{8'h34, 8'h80};
    expQ.push_back(mkItem(EV_BUS, 32'h10, 1'b0, 8'h00, 32'h0, 1'b0));
    expQ.push_back(mkItem(EV_BUS, 32'h11, 1'b0, 8'h00, 32'h0, 1'b0));
    expQ.push_back(mkItem(EV_DONE, 32'h0, 1'b0, 8'h00, 32'hFFFF8034, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, sc, rc);
    checkOutput("lh stall cycles", 32'(sc), 32'd3);

    $display("[TB] sh across address wrap with wait states");
    slvWait = 2;
    expQ.push_back(mkItem(EV_BUS, 32'hFFFFFFFF, 1'b1, 8'hDD, 32'h0, 1'b0));
    expQ.push_back(mkItem(EV_BUS, 32'h00000000, 1'b1, 8'hCC, 32'h0, 1'b0));
    expQ.push_back(mkItem(EV_DONE, 32'h0, 1'b0, 8'h00, 32'hFFFF8034, 1'b0));
    applyStimulus(1'b0, 1'b1, 3'b001, 32'hFFFFFFFF, 32'hAABBCCDD, sc, rc);
    checkOutput("sh stall cycles", 32'(sc), 32'd7);
    checkOutput("sh req cycles", 32'(rc), 32'd6);
    slvWait = 0;

    $display("[TB] illegal requests");
    applyIllegal(1'b1, 1'b0, 3'b011);
    applyIllegal(1'b1, 1'b1, 3'b010);
    applyIllegal(1'b0, 1'b1, 3'b100);

    $display("[TB] sw timeout then lw");
    slvMute = 1'b1;
    expQ.push_back(mkItem(EV_DONE, 32'h0, 1'b0, 8'h00, 32'hFFFF8034, 1'b1));
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h40, 32'h01020304, sc, rc);
    checkOutput("timeout stall cycles", 32'(sc), 32'd5);
    checkOutput("timeout req cycles", 32'(rc), 32'd4);
    slvMute = 1'b0;
    slvQ = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++)
      expQ.push_back(mkItem(EV_BUS, 32'h200 + 32'(i), 1'b0, 8'h00, 32'h0, 1'b0));
    expQ.push_back(mkItem(EV_DONE, 32'h0, 1'b0, 8'h00, 32'h44332211, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, sc, rc);
    checkOutput("lw after timeout stall", 32'(sc), 32'd5);

    $display("[TB] reset in the middle of lw");
    slvQ = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    expQ.push_back(mkItem(EV_BUS, 32'h300, 1'b0, 8'h00, 32'h0, 1'b0));
    @(posedge clk);
    #1;
    memRead = 1'b1;
    rwType  = 3'b010;
    addr    = 32'h300;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    memRead = 1'b0;
    #1;
    checkOutput("mid-reset bus_req", 32'(busIf.bus_req), 32'h0);
    checkOutput("mid-reset stall", 32'(stall), 32'h0);
    checkOutput("mid-reset rdata", rdata, 32'h0);
    slvQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    slvQ = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++)
      expQ.push_back(mkItem(EV_BUS, 32'h400 + 32'(i), 1'b0, 8'h00, 32'h0, 1'b0));
    expQ.push_back(mkItem(EV_DONE, 32'h0, 1'b0, 8'h00, 32'h04030201, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, sc, rc);
    checkOutput("lw after reset stall", 32'(sc), 32'd5);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
